// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared sizes, FSM encoding and coefficient type for the coefficient loader
package fir_pkg;

    localparam int NTAPS    = 64;
    localparam int DW       = 16;
    localparam int AW       = $clog2(NTAPS);
    localparam int HOLD_CYC = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STREAM = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    typedef logic signed [DW-1:0] coeff_t;

endpackage

// File: rtl/fir_coeff_loader_if.sv
// rtl/fir_coeff_loader_if.sv - host/core signal bundle of the loader; csum present with COEFF_CHECKSUM_EN
interface fir_coeff_loader_if;
    import fir_pkg::*;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    coeff_t        wr_data;
    logic          start;
    logic          cload;
    logic [AW-1:0] caddr;
    coeff_t        cin;
    logic          busy;
    logic          done;
    logic          req_err;
`ifdef COEFF_CHECKSUM_EN
    logic signed [DW+AW-1:0] csum;

    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  cload, caddr, cin, busy, done, req_err, csum
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output cload, caddr, cin, busy, done, req_err, csum
    );
`else
    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  cload, caddr, cin, busy, done, req_err
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output cload, caddr, cin, busy, done, req_err
    );
`endif

endinterface

// File: rtl/fir_coeff_buf.sv
// rtl/fir_coeff_buf.sv - NTAPS x DW staging register file, one write port, one registered read port
module fir_coeff_buf
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  coeff_t        wdata_i,
    input  logic          rd_en_i,
    input  logic          rd_clr_i,
    input  logic [AW-1:0] raddr_i,
    output coeff_t        rdata_o
);

    coeff_t mem_q [NTAPS];
    coeff_t rdata_q;

    // rd_clr wins over rd_en so the read register doubles as the zeroed cin outside a load
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            if (rd_clr_i) begin
                rdata_q <= '0;
            end else if (rd_en_i) begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_coeff_loader.sv
// rtl/fir_coeff_loader.sv - streams the staging buffer into fir_core CMEM; COEFF_CHECKSUM_EN adds csum
module fir_coeff_loader
    import fir_pkg::*;
(
    input  logic              clk2,
    input  logic              rst,
    fir_coeff_loader_if.slave bus
);

    state_e        state_q, state_d;
    logic [AW-1:0] tap_q, tap_d;
    logic [3:0]    hold_q, hold_d;
    logic          cload_q, busy_q, done_q, req_err_q;
    logic [AW-1:0] caddr_q;

    logic in_run;
    logic wr_ok;
    logic rd_en;
    logic rd_clr;

    assign in_run = (state_q == ST_SETUP) || (state_q == ST_STREAM) || (state_q == ST_HOLD);
    assign wr_ok  = bus.wr_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign rd_en  = (state_q == ST_STREAM);
    assign rd_clr = !((state_q == ST_STREAM) || (state_q == ST_HOLD));

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_STREAM;
                tap_d   = '0;
            end
            ST_STREAM: begin
                if (tap_q == AW'(NTAPS - 1)) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (hold_q == 4'(HOLD_CYC - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the current state, so they trail the state by one edge
    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tap_q     <= '0;
            hold_q    <= '0;
            cload_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            req_err_q <= 1'b0;
            caddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            hold_q    <= hold_d;
            cload_q   <= in_run;
            busy_q    <= in_run;
            done_q    <= (state_q == ST_DONE);
            req_err_q <= (bus.start && (in_run || (state_q == ST_DONE))) ||
                         (bus.wr_en && in_run);
            case (state_q)
                ST_STREAM: caddr_q <= tap_q;
                ST_HOLD:   caddr_q <= caddr_q;
                default:   caddr_q <= '0;
            endcase
        end
    end

    fir_coeff_buf u_buf (
        .clk      (clk2),
        .rst      (rst),
        .we_i     (wr_ok),
        .waddr_i  (bus.wr_addr),
        .wdata_i  (bus.wr_data),
        .rd_en_i  (rd_en),
        .rd_clr_i (rd_clr),
        .raddr_i  (tap_q),
        .rdata_o  (bus.cin)
    );

    assign bus.cload   = cload_q;
    assign bus.caddr   = caddr_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.req_err = req_err_q;

`ifdef COEFF_CHECKSUM_EN
    logic                    acc_q;
    logic signed [DW+AW-1:0] csum_q;

    // acc_q marks the cycles where cin carries a value read during STREAM
    always_ff @(posedge clk2) begin
        if (rst) begin
            acc_q  <= 1'b0;
            csum_q <= '0;
        end else begin
            acc_q <= (state_q == ST_STREAM);
            if (state_q == ST_SETUP) begin
                csum_q <= '0;
            end else if (acc_q) begin
                csum_q <= csum_q + {{AW{bus.cin[DW-1]}}, bus.cin};
            end
        end
    end

    assign bus.csum = csum_q;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb/tb_fir_coeff_loader.sv - self-checking bench for fir_coeff_loader
module tb_fir_coeff_loader;
    import fir_pkg::*;

    localparam int H    = HOLD_CYC;
    localparam int TEND = 68 + H;

    logic clk2 = 1'b0;
    logic rst;

    always #5 clk2 = ~clk2;

    fir_coeff_loader_if bus();

    fir_coeff_loader dut (
        .clk2 (clk2),
        .rst  (rst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] ref_buf [64];
    logic [15:0] snap    [64];

    typedef struct {
        string       name;
        int          kind;
        int          dt;
        logic [5:0]  addr;
        logic [15:0] data;
        bit          exp_err;
        bit          exp_done;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [31:0] pack(bit cl, bit bz, bit dn, bit er, logic [5:0] a, logic [15:0] d);
        return {6'd0, cl, bz, dn, er, a, d};
    endfunction

    function automatic logic [31:0] outs();
        return {6'd0, bus.cload, bus.busy, bus.done, bus.req_err, bus.caddr, bus.cin};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cload,busy,done,req_err,caddr,cin)", name, got, exp);
        end
    endtask

    task automatic write_word(input logic [5:0] a, input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(posedge clk2);
        #1;
        bus.wr_en = 1'b0;
        ref_buf[a] = d;
    endtask

    // kind: 0 none, 1 extra start, 2 write, 3 reset; disturbance is sampled at edge N+dt
    task automatic do_load(input string name, input int kind, input int dt,
                           input logic [5:0] da, input logic [15:0] dd,
                           input bit exp_err, input bit exp_done,
                           input bit same_wr, input logic [5:0] sa, input logic [15:0] sd);
        logic [31:0] e;
        bit          cl;
        logic [5:0]  a;
        logic [15:0] d;
        if (same_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = sa;
            bus.wr_data = sd;
            ref_buf[sa] = sd;
        end
        bus.start = 1'b1;
        for (int k = 0; k < 64; k++) snap[k] = ref_buf[k];
        @(posedge clk2);
        #1;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        for (int t = 1; t <= TEND; t++) begin
            if (t == dt) begin
                case (kind)
                    1: bus.start = 1'b1;
                    2: begin
                        bus.wr_en   = 1'b1;
                        bus.wr_addr = da;
                        bus.wr_data = dd;
                    end
                    3: rst = 1'b1;
                    default: ;
                endcase
            end
            @(posedge clk2);
            #1;
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            rst       = 1'b0;
            if (t == dt && kind == 2 && dt > 65 + H) ref_buf[da] = dd;
            if (t == dt && kind == 3) for (int k = 0; k < 64; k++) ref_buf[k] = '0;
            if (kind == 3 && t >= dt) begin
                e = pack(0, 0, 0, 0, 6'd0, 16'd0);
            end else begin
                cl = (t <= 65 + H);
                if (t >= 2 && t <= 65) begin
                    a = 6'(t - 2);
                    d = snap[t - 2];
                end else if (t > 65 && t <= 65 + H) begin
                    a = 6'd63;
                    d = snap[63];
                end else begin
                    a = 6'd0;
                    d = 16'd0;
                end
                e = pack(cl, cl, exp_done && (t == 66 + H),
                         exp_err && (kind == 1 || kind == 2) && (t == dt), a, d);
            end
            @(negedge clk2);
            check($sformatf("%s_t%0d", name, t), outs(), e);
        end
`ifdef COEFF_CHECKSUM_EN
        if (exp_done) begin
            int s = 0;
            for (int k = 0; k < 64; k++) s += int'($signed(snap[k]));
            total++;
            if (bus.csum !== 22'(s)) begin
                bad++;
                $display("FAIL %s_csum got=%h exp=%h", name, bus.csum, 22'(s));
            end
        end
`endif
    endtask

    initial begin
        tbl[0] = '{"plain",          0, 0,  6'd0,  16'h0000, 1'b0, 1'b1};
        tbl[1] = '{"start_caddr20",  1, 23, 6'd0,  16'h0000, 1'b1, 1'b1};
        tbl[2] = '{"wr_in_hold",     2, 67, 6'd10, 16'h1234, 1'b1, 1'b1};
        tbl[3] = '{"wr_in_done",     2, 66 + H, 6'd11, 16'h5555, 1'b0, 1'b1};
        tbl[4] = '{"start_in_done",  1, 66 + H, 6'd0,  16'h0000, 1'b1, 1'b1};
        tbl[5] = '{"start_in_setup", 1, 1,  6'd0,  16'h0000, 1'b1, 1'b1};
        tbl[6] = '{"wr_in_stream",   2, 2,  6'd3,  16'hBEEF, 1'b1, 1'b1};
        tbl[7] = '{"rst_caddr30",    3, 33, 6'd0,  16'h0000, 1'b0, 1'b0};
        tbl[8] = '{"after_rst",      0, 0,  6'd0,  16'h0000, 1'b0, 1'b1};

        for (int k = 0; k < 64; k++) ref_buf[k] = '0;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        repeat (2) @(posedge clk2);
        @(negedge clk2);
        check("reset", outs(), pack(0, 0, 0, 0, 6'd0, 16'd0));
        @(posedge clk2);
        #1;
        rst = 1'b0;
        @(negedge clk2);
        check("idle_after_reset", outs(), pack(0, 0, 0, 0, 6'd0, 16'd0));

        for (int k = 0; k < 64; k++) write_word(6'(k), 16'(k + 1));
        do_load("ramp", 0, 0, 6'd0, 16'd0, 1'b0, 1'b1, 1'b0, 6'd0, 16'd0);

        for (int k = 0; k < 64; k++) write_word(6'(k), 16'h0000);
        write_word(6'd5, 16'h8000);
        write_word(6'd6, 16'h7FFF);
        do_load("extremes", 0, 0, 6'd0, 16'd0, 1'b0, 1'b1, 1'b0, 6'd0, 16'd0);

        for (int k = 0; k < 64; k++) write_word(6'(k), 16'(k * 257));
        for (int i = 0; i < 9; i++) begin
            do_load(tbl[i].name, tbl[i].kind, tbl[i].dt, tbl[i].addr, tbl[i].data,
                    tbl[i].exp_err, tbl[i].exp_done, 1'b0, 6'd0, 16'd0);
        end

        do_load("same_cycle_wr", 0, 0, 6'd0, 16'd0, 1'b0, 1'b1, 1'b1, 6'd0, 16'h00AA);

        for (int r = 0; r < 6; r++) begin
            int          kind;
            int          dt;
            int          nw;
            logic [5:0]  da;
            logic [15:0] dd;
            nw = int'($urandom_range(3, 8));
            for (int j = 0; j < nw; j++) write_word(6'($urandom_range(0, 63)), 16'($urandom));
            kind = int'($urandom_range(0, 3));
            dt   = (kind == 2) ? int'($urandom_range(1, TEND)) : int'($urandom_range(1, 66 + H));
            if (kind == 0) dt = 0;
            da = 6'($urandom_range(0, 63));
            dd = 16'($urandom);
            do_load($sformatf("rand%0d_k%0d", r, kind), kind, dt, da, dd,
                    (kind == 1) || (kind == 2 && dt <= 65 + H), kind != 3,
                    1'b0, 6'd0, 16'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
